// File: rtl/pwm_duty_loader.sv
// Duty-command loader for the 22-bit PWM stage: shift-add scaling, saturation and wrap-aligned commit.
// Optional build macro SLEW_LIMIT_EN limits each per-wrap change of dato to MAX_STEP.
module pwm_duty_loader #(
    parameter int          DIN_W      = 8,
    parameter logic [21:0] STEP       = 22'd16448,
`ifdef SLEW_LIMIT_EN
    parameter logic [21:0] MAX_STEP   = 22'd262144,
`endif
    parameter logic [21:0] RESET_DUTY = 22'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [DIN_W-1:0] in_data,
    output logic             in_ready,
    input  logic [21:0]      counter,
    output logic [21:0]      dato,
    output logic             busy,
    output logic             loaded
);

    localparam int ACC_W = DIN_W + 22;
    localparam int IDX_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MULT      = 2'd1;
    localparam logic [1:0] WAIT_WRAP = 2'd2;

    localparam logic [21:0] DUTY_MAX = 22'h3FFFFF;

    logic [1:0]       state;
    logic [1:0]       nextState;
    logic [DIN_W-1:0] cmd;
    logic [ACC_W-1:0] stepSh;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] accNext;
    logic [IDX_W-1:0] idx;
    logic [21:0]      target;
    logic [21:0]      targetNext;
    logic [21:0]      datoNext;
    logic             commitFinal;
    logic             handshake;
    logic             lastBit;
    logic             atWrap;

    assign handshake  = in_valid & in_ready;
    assign lastBit    = (idx == IDX_W'(DIN_W - 1));
    assign atWrap     = (counter == DUTY_MAX);
    assign busy       = (state != IDLE);
    assign accNext    = acc + (cmd[0] ? stepSh : '0);
    assign targetNext = (accNext > ACC_W'(DUTY_MAX)) ? DUTY_MAX : accNext[21:0];

`ifdef SLEW_LIMIT_EN
    logic        slewUp;
    logic [21:0] slewDiff;
`endif

    // Next-state and commit decision; dato may only move on a wrap while waiting.
    always_comb begin
        nextState   = state;
        datoNext    = dato;
        commitFinal = 1'b0;
`ifdef SLEW_LIMIT_EN
        slewUp   = (target >= dato);
        slewDiff = slewUp ? (target - dato) : (dato - target);
`endif
        case (state)
            IDLE: begin
                if (handshake) begin
                    nextState = MULT;
                end
            end
            MULT: begin
                if (lastBit) begin
                    nextState = WAIT_WRAP;
                end
            end
            WAIT_WRAP: begin
                if (atWrap) begin
`ifdef SLEW_LIMIT_EN
                    if (slewDiff <= MAX_STEP) begin
                        datoNext    = target;
                        commitFinal = 1'b1;
                        nextState   = IDLE;
                    end else begin
                        datoNext = slewUp ? (dato + MAX_STEP) : (dato - MAX_STEP);
                    end
`else
                    datoNext    = target;
                    commitFinal = 1'b1;
                    nextState   = IDLE;
`endif
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Control registers; in_ready reopens only after a full idle cycle following a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            dato     <= RESET_DUTY;
            loaded   <= 1'b0;
        end else begin
            state    <= nextState;
            in_ready <= (state == IDLE) && (nextState == IDLE);
            dato     <= datoNext;
            loaded   <= commitFinal;
        end
    end

    // Shift-add multiplier: command shifts right, step shifts left, one bit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd    <= '0;
            stepSh <= '0;
            acc    <= '0;
            idx    <= '0;
            target <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        cmd    <= in_data;
                        stepSh <= ACC_W'(STEP);
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                MULT: begin
                    acc    <= accNext;
                    cmd    <= cmd >> 1;
                    stepSh <= stepSh << 1;
                    idx    <= idx + 1'b1;
                    if (lastBit) begin
                        target <= targetNext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_loader.sv
// Self-checking bench for pwm_duty_loader: two instances (default STEP and STEP=20000) against a
// transaction-level model; the SLEW_LIMIT_EN build runs the slew scenario instead of the jump tests.
module tb_pwm_duty_loader;

    localparam int          DIN_W    = 8;
    localparam logic [21:0] DUTY_MAX = 22'h3FFFFF;
    localparam longint      MAX_STEP = 262144;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [21:0] counter;
    logic        in_ready0, busy0, loaded0;
    logic [21:0] dato0;
    logic        in_ready1, busy1, loaded1;
    logic [21:0] dato1;

    int checks = 0;
    int errors = 0;
    bit autoCount = 1'b0;

    pwm_duty_loader dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .counter(counter), .dato(dato0), .busy(busy0), .loaded(loaded0)
    );

    pwm_duty_loader #(.STEP(22'd20000)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .counter(counter), .dato(dato1), .busy(busy1), .loaded(loaded1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel is idle, or holding a command accepted at edge hsCyc whose scaled,
    // saturated product may be committed at any wrap from edge hsCyc+DIN_W+1 on.
    longint      stepOf [2] = '{16448, 20000};
    longint      cyc;
    longint      hsCyc   [2];
    logic [21:0] mTarget [2];
    logic [21:0] mDato   [2];
    bit          mBusy   [2];
    bit          mReady  [2];
    bit          mLoaded [2];

    function automatic logic [21:0] sat(input longint v);
        longint lim;
        lim = longint'(DUTY_MAX);
        return (v > lim) ? DUTY_MAX : 22'(v);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0;
            for (int c = 0; c < 2; c++) begin
                mBusy[c] = 0; mReady[c] = 0; mLoaded[c] = 0; mDato[c] = '0; mTarget[c] = '0; hsCyc[c] = 0;
            end
        end else begin
            cyc++;
            for (int c = 0; c < 2; c++) begin
                bit wasBusy;
                bit hs;
                longint d;
                wasBusy = mBusy[c];
                hs = 0;
                mLoaded[c] = 0;
                if (!wasBusy) begin
                    if (in_valid && mReady[c]) begin
                        hs = 1;
                        mBusy[c] = 1;
                        hsCyc[c] = cyc;
                        mTarget[c] = sat(longint'(in_data) * stepOf[c]);
                    end
                end else if (cyc >= hsCyc[c] + DIN_W + 1 && counter == DUTY_MAX) begin
                    d = longint'(mTarget[c]) - longint'(mDato[c]);
`ifdef SLEW_LIMIT_EN
                    if (d <= MAX_STEP && d >= -MAX_STEP) begin
                        mDato[c] = mTarget[c]; mLoaded[c] = 1; mBusy[c] = 0;
                    end else begin
                        mDato[c] = 22'(longint'(mDato[c]) + ((d > 0) ? MAX_STEP : -MAX_STEP));
                    end
`else
                    mDato[c] = mTarget[c]; mLoaded[c] = 1; mBusy[c] = 0;
                    if (d == 0) mDato[c] = mTarget[c];
`endif
                end
                mReady[c] = !wasBusy && !hs;
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        checkOutput("ch0 dato", dato0, mDato[0]);
        checkOutput("ch0 busy", busy0, mBusy[0]);
        checkOutput("ch0 in_ready", in_ready0, mReady[0]);
        checkOutput("ch0 loaded", loaded0, mLoaded[0]);
        checkOutput("ch1 dato", dato1, mDato[1]);
        checkOutput("ch1 busy", busy1, mBusy[1]);
        checkOutput("ch1 in_ready", in_ready1, mReady[1]);
        checkOutput("ch1 loaded", loaded1, mLoaded[1]);
    end

    task automatic applyStimulus(input bit valid, input logic [7:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    // Counter runs 0x3FFFF0..0x3FFFFF,0..15 so wraps come every 32 cycles.
    task automatic tick();
        @(negedge clk);
        if (autoCount) counter = (counter == 22'd15) ? 22'h3FFFF0 : counter + 22'd1;
    endtask

    task automatic waitReady(input string tag);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready0) begin got = 1; break; end
            tick();
        end
        checkOutput({tag, " ready wait"}, got, 1);
    endtask

    task automatic waitLoaded(input int budget, input string tag);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (loaded0) begin got = 1; break; end
        end
        checkOutput({tag, " loaded wait"}, got, 1);
    endtask

    task automatic sendCmd(input logic [7:0] data, input string tag);
        waitReady(tag);
        applyStimulus(1'b1, data);
        tick();
        applyStimulus(1'b0, 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        counter = 22'd0;
        applyStimulus(1'b0, 8'd0);
        repeat (3) @(negedge clk);
        checkOutput("reset dato", dato0, 0);
        checkOutput("reset busy", busy0, 0);
        checkOutput("reset loaded", loaded0, 0);
        checkOutput("reset in_ready", in_ready0, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready after release", in_ready0, 1);

`ifdef SLEW_LIMIT_EN
        autoCount = 1'b1;
        counter = 22'h3FFFF0;
        sendCmd(8'd255, "slew");
        for (int i = 0; i < 200; i++) begin
            if (dato0 != 22'd0) break;
            tick();
        end
        checkOutput("slew first step", dato0, 262144);
        checkOutput("slew busy", busy0, 1);
        checkOutput("slew no loaded", loaded0, 0);
        waitLoaded(2000, "slew");
        checkOutput("slew final ch0", dato0, 4194240);
        checkOutput("slew final ch1", dato1, 4194303);
`else
        autoCount = 1'b1;
        counter = 22'h3FFFF0;
        sendCmd(8'd128, "d128");
        waitLoaded(200, "d128");
        checkOutput("d128 ch0", dato0, 2105344);
        checkOutput("d128 ch1", dato1, 2560000);

        sendCmd(8'd255, "d255");
        waitLoaded(200, "d255");
        checkOutput("d255 ch0", dato0, 4194240);
        checkOutput("d255 ch1 sat", dato1, 4194303);

        sendCmd(8'd0, "d0");
        waitLoaded(200, "d0");
        checkOutput("d0 ch0", dato0, 0);

        // Valid held high while data changes: second command taken the cycle after loaded.
        waitReady("b2b");
        applyStimulus(1'b1, 8'd10);
        tick();
        applyStimulus(1'b1, 8'd20);
        waitLoaded(200, "b2b first");
        checkOutput("b2b first dato", dato0, 164480);
        tick();
        checkOutput("b2b ready after loaded", in_ready0, 1);
        tick();
        checkOutput("b2b second accepted", busy0, 1);
        waitLoaded(200, "b2b second");
        applyStimulus(1'b0, 8'd0);
        checkOutput("b2b second dato", dato0, 328960);

        // Wrap on the final multiply cycle must be missed.
        autoCount = 1'b0;
        counter = 22'd5;
        waitReady("miss");
        applyStimulus(1'b1, 8'd3);
        tick();
        applyStimulus(1'b0, 8'd0);
        repeat (7) tick();
        counter = DUTY_MAX;
        tick();
        counter = 22'd5;
        checkOutput("miss busy", busy0, 1);
        checkOutput("miss no loaded", loaded0, 0);
        checkOutput("miss dato held", dato0, 328960);
        repeat (5) tick();
        counter = DUTY_MAX;
        tick();
        counter = 22'd6;
        checkOutput("miss late loaded", loaded0, 1);
        checkOutput("miss late dato", dato0, 49344);

        // Asynchronous reset in the middle of a multiply.
        autoCount = 1'b1;
        counter = 22'h3FFFF0;
        sendCmd(8'd200, "areset");
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("areset dato", dato0, 0);
        checkOutput("areset busy", busy0, 0);
        checkOutput("areset in_ready", in_ready0, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("areset ready", in_ready0, 1);
        checkOutput("areset dato after", dato0, 0);
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
